// File: rtl/conv_stream_pkg.sv
// Shared constants for the convolution streaming path: default pixel width,
// default kernel size, and the flattened window element offset used by both
// the window generator and the downstream convolution stage.
package conv_stream_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int K_DEFAULT      = 3;

    // Bit offset of window element (r,c) in a flattened KxK window;
    // r=0 is the oldest (top) row, c=0 the leftmost column.
    function automatic int win_offset(input int r, input int c, input int k, input int data_w);
        return (r * k + c) * data_w;
    endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// One image row of delay: each enabled cycle writes i_data and presents the
// value written DEPTH enabled cycles earlier on o_data.
module conv2d_line_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;

    // Circular pointer tracks the column of the pixel being accepted.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (i_en)
            r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end

    // Row storage: read-before-write at the same slot yields a one-row delay.
    // NOTE: the storage array has no reset; stale rows are never emitted because output is row-gated.
    always_ff @(posedge clk) begin
        if (i_en)
            r_mem[r_ptr] <= i_data;
    end

    assign o_data = r_mem[r_ptr];

endmodule

// File: rtl/conv2d_window_gen.sv
// Sliding KxK window generator for a raster pixel stream (valid padding,
// stride 1). K-1 line buffers supply the older rows; a KxK register window
// shifts one column per accepted pixel. Output is registered (latency 1)
// with valid/ready flow control.
// Optional frame flags (win_first / win_last): define CONV2D_WINGEN_FRAME_FLAGS_EN.
module conv2d_window_gen
    import conv_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = K_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [DATA_W-1:0]        input_data,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [K*K*DATA_W-1:0]    window_data
`ifdef CONV2D_WINGEN_FRAME_FLAGS_EN
    ,
    output logic                     win_first,
    output logic                     win_last
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]                   r_col;
    logic [ROW_W-1:0]                   r_row;
    logic                               r_valid;
    logic [K-1:0][K-1:0][DATA_W-1:0]    r_win;

    // w_tap[0] is the incoming pixel; w_tap[i] is the same column i rows earlier.
    logic [K-1:0][DATA_W-1:0]           w_tap;
    logic                               w_accept;
    logic                               w_col_wrap;
    logic                               w_row_wrap;
    logic                               w_completes;

    assign ready_in    = !r_valid || ready_out;
    assign w_accept    = valid_in && ready_in;
    assign w_col_wrap  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_wrap  = (r_row == ROW_W'(IMG_H - 1));
    // A window is complete only once K rows and K columns of the current row are present,
    // which also guarantees no window straddles a row wrap.
    assign w_completes = (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1));

    assign w_tap[0] = input_data;

    generate
        for (genvar i = 0; i < K - 1; i++) begin : g_line_buf
            conv2d_line_buffer #(
                .DATA_W (DATA_W),
                .DEPTH  (IMG_W)
            ) u_line_buf (
                .clk    (clk),
                .rst    (rst),
                .i_en   (w_accept),
                .i_data (w_tap[i]),
                .o_data (w_tap[i+1])
            );
        end
    endgenerate

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Window shifts left one column per accepted pixel; the new right column
    // takes the oldest row from the deepest line buffer and the newest from input_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    r_win[r][c] <= r_win[r][c+1];
                r_win[r][K-1] <= w_tap[K-1-r];
            end
        end
    end

    // Output valid: set by a completing pixel, cleared when retired without a replacement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= 1'b0;
        else if (w_accept)
            r_valid <= w_completes;
        else if (ready_out)
            r_valid <= 1'b0;
    end

    assign valid_out = r_valid;

    generate
        for (genvar r = 0; r < K; r++) begin : g_row
            for (genvar c = 0; c < K; c++) begin : g_col
                localparam int OFF = win_offset(r, c, K, DATA_W);
                assign window_data[OFF +: DATA_W] = r_win[r][c];
            end
        end
    endgenerate

`ifdef CONV2D_WINGEN_FRAME_FLAGS_EN
    logic r_win_first;
    logic r_win_last;

    // Frame position flags travel with the window and hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_first <= 1'b0;
            r_win_last  <= 1'b0;
        end else if (w_accept) begin
            r_win_first <= (r_row == ROW_W'(K - 1)) && (r_col == COL_W'(K - 1));
            r_win_last  <= w_row_wrap && w_col_wrap;
        end
    end

    assign win_first = r_win_first;
    assign win_last  = r_win_last;
`endif

endmodule

// File: tb/tb_conv2d_window_gen.sv
// Self-checking bench for conv2d_window_gen (IMG_W=IMG_H=8, K=3, DATA_W=32).
// Expected windows are computed from whole-frame images; the flow-control
// model tracks only whether a window is pending.
module tb_conv2d_window_gen;

    localparam int DW       = 32;
    localparam int W        = 8;
    localparam int H        = 8;
    localparam int KK       = 3;
    localparam int NWIN     = (H - KK + 1) * (W - KK + 1);
    localparam int WIN_BITS = KK * KK * DW;

    typedef logic [WIN_BITS-1:0] win_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_out = 1'b0;
    logic [DW-1:0] input_data = '0;
    logic          ready_in;
    logic          valid_out;
    win_t          window_data;
`ifdef CONV2D_WINGEN_FRAME_FLAGS_EN
    logic          win_first;
    logic          win_last;
`endif

    always #5 clk = ~clk;

    conv2d_window_gen #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H),
        .K      (KK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .input_data  (input_data),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .window_data (window_data)
`ifdef CONV2D_WINGEN_FRAME_FLAGS_EN
        ,
        .win_first   (win_first),
        .win_last    (win_last)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] pix_q[$];
    win_t          exp_q[$];
    bit            first_q[$];
    bit            last_q[$];
    win_t          got_q[$];
    int            win_count;
    int            acc18_cyc;
    int            first_valid_cyc;

    // Window anchored at top-left (r0,c0) of an image whose pixel value is row*W+col.
    function automatic win_t ramp_win(input int r0, input int c0);
        win_t w = '0;
        for (int i = 0; i < KK; i++)
            for (int j = 0; j < KK; j++)
                w[(i*KK+j)*DW +: DW] = DW'((r0 + i) * W + (c0 + j));
        return w;
    endfunction

    // Queue one frame's pixels and every valid-mode window it must produce.
    function automatic void build_frame(input bit rand_pix);
        logic [DW-1:0] img [H][W];
        win_t w;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[r][c] = rand_pix ? DW'($urandom) : DW'(r * W + c);
                pix_q.push_back(img[r][c]);
            end
        for (int r = KK - 1; r < H; r++)
            for (int c = KK - 1; c < W; c++) begin
                w = '0;
                for (int i = 0; i < KK; i++)
                    for (int j = 0; j < KK; j++)
                        w[(i*KK+j)*DW +: DW] = img[r-KK+1+i][c-KK+1+j];
                exp_q.push_back(w);
                first_q.push_back(r == KK - 1 && c == KK - 1);
                last_q.push_back(r == H - 1 && c == W - 1);
            end
    endfunction

    function automatic void clear_model();
        pix_q.delete();
        exp_q.delete();
        first_q.delete();
        last_q.delete();
        got_q.delete();
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Drive queued pixels with random input gaps and output stalls; check
    // valid/ready every cycle, hold under stall, and each retired window.
    // hold_at: force a 5-cycle stall when this many windows have retired (-1 = none).
    // stop_after: stop driving after this many accepted pixels, leaving the last one
    // presented for the next edge (-1 = send all and drain).
    task automatic stream(input int stall_pct, input int gap_pct, input int hold_at, input int stop_after);
        bit   exp_valid  = 1'b0;
        bit   prev_stall = 1'b0;
        bit   held_done  = 1'b0;
        bit   retire;
        bit   accept;
        bit   ef;
        bit   el;
        int   stall_left = 0;
        int   sent       = 0;
        int   budget     = 0;
        int   p;
        int   r;
        int   c;
        win_t prev_win   = '0;
        win_t w;
        win_count       = 0;
        acc18_cyc       = -1;
        first_valid_cyc = -1;
        got_q.delete();
        while ((pix_q.size() > 0 && (stop_after < 0 || sent < stop_after)) || (exp_valid && stop_after < 0)) begin
            @(negedge clk);
            budget++;
            if (budget > 20000) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout: sent=%0d windows=%0d", sent, win_count);
                break;
            end
            if (exp_valid && win_count == hold_at && !held_done) begin
                stall_left = 5;
                held_done  = 1'b1;
            end
            if (stall_left > 0) begin
                ready_out = 1'b0;
                stall_left--;
            end else begin
                ready_out = ($urandom_range(99) >= stall_pct);
            end
            #1;
            checks++;
            if (valid_out !== exp_valid) begin
                errors++;
                $display("FAIL valid_out: got=%b exp=%b at pixel %0d", valid_out, exp_valid, sent);
            end
            checks++;
            if (ready_in !== (!exp_valid || ready_out)) begin
                errors++;
                $display("FAIL ready_in: got=%b exp=%b", ready_in, (!exp_valid || ready_out));
            end
            if (prev_stall) begin
                checks++;
                if (window_data !== prev_win) begin
                    errors++;
                    $display("FAIL stall_hold: got=%h exp=%h", window_data, prev_win);
                end
            end
            if (valid_out === 1'b1 && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            retire = exp_valid && ready_out;
            if (retire) begin
                w  = exp_q.pop_front();
                ef = first_q.pop_front();
                el = last_q.pop_front();
                checks++;
                if (window_data !== w) begin
                    errors++;
                    $display("FAIL window[%0d]: got=%h exp=%h", win_count, window_data, w);
                end
`ifdef CONV2D_WINGEN_FRAME_FLAGS_EN
                checks++;
                if (win_first !== ef || win_last !== el) begin
                    errors++;
                    $display("FAIL frame_flags[%0d]: got first=%b last=%b exp first=%b last=%b",
                             win_count, win_first, win_last, ef, el);
                end
`endif
                got_q.push_back(window_data);
                win_count++;
            end
            prev_stall = exp_valid && !ready_out;
            prev_win   = window_data;
            if (pix_q.size() > 0 && (stop_after < 0 || sent < stop_after) && $urandom_range(99) >= gap_pct) begin
                valid_in   = 1'b1;
                input_data = pix_q[0];
            end else begin
                valid_in   = 1'b0;
                input_data = DW'($urandom);
            end
            accept = valid_in && (!exp_valid || ready_out);
            if (accept) begin
                p = sent % (W * H);
                r = p / W;
                c = p % W;
                void'(pix_q.pop_front());
                if (p == 18 && acc18_cyc < 0)
                    acc18_cyc = cyc;
                exp_valid = (r >= KK - 1 && c >= KK - 1);
                sent++;
            end else if (retire) begin
                exp_valid = 1'b0;
            end
        end
        if (stop_after < 0) begin
            @(negedge clk);
            valid_in  = 1'b0;
            ready_out = 1'b0;
        end
    endtask

    task automatic check_frame_summary(input string name, input int exp_count);
        checks++;
        if (win_count != exp_count || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_count: got=%0d exp=%0d leftover=%0d", name, win_count, exp_count, exp_q.size());
        end
        checks++;
        if (got_q.size() < 1 || got_q[0] !== ramp_win(0, 0)) begin
            errors++;
            $display("FAIL %s_first_window: got=%h exp=%h", name, (got_q.size() > 0) ? got_q[0] : '0, ramp_win(0, 0));
        end
        checks++;
        if (got_q.size() < exp_count || got_q[exp_count-1] !== ramp_win(H - KK, W - KK)) begin
            errors++;
            $display("FAIL %s_last_window: got=%h exp=%h", name,
                     (got_q.size() >= exp_count) ? got_q[exp_count-1] : '0, ramp_win(H - KK, W - KK));
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ready_out = 1'b0;
        valid_in  = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got valid_out=%b ready_in=%b exp 0/1", valid_out, ready_in);
        end
        checks++;
        if (window_data !== '0) begin
            errors++;
            $display("FAIL reset_window: got=%h exp=0", window_data);
        end
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        build_frame(1'b0);
        stream(0, 0, -1, -1);
        check_frame_summary("stream", NWIN);
        checks++;
        if (first_valid_cyc - acc18_cyc != 1) begin
            errors++;
            $display("FAIL stream_latency: got=%0d cycles exp=1", first_valid_cyc - acc18_cyc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        build_frame(1'b0);
        stream(30, 20, 3, -1);
        check_frame_summary("stall", NWIN);
    endtask

    task automatic test_row_wrap();
        do_reset();
        build_frame(1'b0);
        stream(20, 10, -1, -1);
        checks++;
        if (got_q.size() < 7 || got_q[5] !== ramp_win(0, W - KK) || got_q[6] !== ramp_win(1, 0)) begin
            errors++;
            $display("FAIL row_wrap: got=%h exp=%h", (got_q.size() >= 7) ? got_q[6] : '0, ramp_win(1, 0));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        build_frame(1'b0);
        build_frame(1'b0);
        stream(0, 0, -1, -1);
        checks++;
        if (win_count != 2 * NWIN || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got=%0d exp=%0d", win_count, 2 * NWIN);
        end
        checks++;
        if (got_q.size() <= NWIN || got_q[NWIN] !== ramp_win(0, 0)) begin
            errors++;
            $display("FAIL b2b_frame2_first: got=%h exp=%h", (got_q.size() > NWIN) ? got_q[NWIN] : '0, ramp_win(0, 0));
        end
    endtask

    task automatic test_random_frames();
        do_reset();
        build_frame(1'b1);
        build_frame(1'b1);
        stream(25, 25, 10, -1);
        checks++;
        if (win_count != 2 * NWIN || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: got=%0d exp=%0d", win_count, 2 * NWIN);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        build_frame(1'b0);
        ready_out = 1'b1;
        stream(0, 0, -1, 31);
        @(posedge clk);
        #2;
        checks++;
        if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_valid: got=%b exp=1", valid_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || window_data !== '0) begin
            errors++;
            $display("FAIL midreset_clear: got valid_out=%b window=%h exp 0/0", valid_out, window_data);
        end
        @(negedge clk);
        valid_in  = 1'b0;
        ready_out = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        build_frame(1'b0);
        stream(0, 0, -1, -1);
        check_frame_summary("midreset", NWIN);
        checks++;
        if (first_valid_cyc - acc18_cyc != 1) begin
            errors++;
            $display("FAIL midreset_latency: got=%0d cycles exp=1", first_valid_cyc - acc18_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_row_wrap();
        test_back_to_back();
        test_random_frames();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv2d_window_gen.md
CONV2D_WINDOW_GEN -- requirements
Module: conv2d_window_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 8, meaning pixels per row (at least K).
REQ-003 The block SHALL have parameter IMG_H, default 8, meaning rows per frame (at least K).
REQ-004 The block SHALL have parameter K, default 3, meaning square kernel size (at least 2).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-007 The block SHALL have port valid_in, input, 1 bit, meaning input_data holds a raster-order pixel.
REQ-008 The block SHALL have port ready_in, output, 1 bit, meaning the block accepts a pixel this cycle.
REQ-009 The block SHALL have port input_data, input, DATA_W bits, meaning the pixel value.
REQ-010 The block SHALL have port valid_out, output, 1 bit, meaning window_data holds a valid KxK window.
REQ-011 The block SHALL have port ready_out, input, 1 bit, meaning the downstream convolution stage accepts the window.
REQ-012 The block SHALL have port window_data, output, K*K*DATA_W bits, meaning the flattened window; element (r,c) sits at bit offset (r*K+c)*DATA_W; r=0 is the top (oldest) row and c=0 the leftmost column.

Function
REQ-013 A pixel SHALL be accepted on each cycle where valid_in and ready_in are both high.
REQ-014 ready_in SHALL equal (not valid_out) or ready_out, combinationally.
REQ-015 Column counter col SHALL increment per accepted pixel, wrapping from IMG_W-1 to 0; on that wrap, row counter row SHALL increment, wrapping from IMG_H-1 to 0.
REQ-016 K-1 line buffers, each IMG_W deep, SHALL hold the previous K-1 rows; each accepted pixel SHALL be written and shifted through in raster order.
REQ-017 A KxK shift-register window SHALL shift left by one column per accepted pixel, loading the new column from the line buffers plus input_data.
REQ-018 When the accepted pixel has row at least K-1 and col at least K-1, valid_out SHALL rise on the next cycle with the completed window; latency is 1 cycle.
REQ-019 Output mode SHALL be valid (no padding), stride 1, giving exactly (IMG_H-K+1)*(IMG_W-K+1) windows per frame.
REQ-020 While valid_out is high and ready_out is low, window_data and valid_out SHALL hold stable and no pixel SHALL be accepted.
REQ-021 When valid_out, ready_out and valid_in are all high in the same cycle, the current window SHALL retire and the next window (if the new pixel completes one) SHALL load with no bubble.
REQ-022 The window SHALL never mix pixels across a row wrap; any window emitted at col K-1 contains only columns 0..K-1.
REQ-023 After the final pixel of a frame, counters SHALL be at (0,0) and the next pixel SHALL start a new frame; the first K-1 rows of the new frame produce no output.

Reset
REQ-024 Asserting rst SHALL immediately force valid_out=0, col=0, row=0; window_data SHALL reset to 0.
REQ-025 Line-buffer storage SHALL NOT require reset; stale contents are never emitted because of the row gating in REQ-018.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is treated as pixel (0,0).

Configuration
REQ-027 With macro CONV2D_WINGEN_FRAME_FLAGS_EN defined, the block SHALL add outputs win_first (high with the first window of a frame) and win_last (high with the last window of a frame), both held under stall like window_data and reset to 0.
REQ-028 Without the macro, those ports and their logic SHALL be absent.

Structure
REQ-029 Package conv_stream_pkg SHALL hold the DATA_W default, the K default, and the window-element offset constant or function shared with the convolution stage.
REQ-030 One sub-module, conv2d_line_buffer, SHALL implement a single IMG_W-deep DATA_W-wide row delay with an enable input; it SHALL be instantiated K-1 times.

Verification (IMG_W=8, IMG_H=8, K=3, pixel value = row*8+col)
REQ-031 Stream 64 pixels with ready_out held high: the first valid_out occurs 1 cycle after pixel 18 is accepted, with window {0,1,2,8,9,10,16,17,18}; exactly 36 windows are produced and the last is {45,46,47,53,54,55,61,62,63}.
REQ-032 Drop ready_out for 5 cycles while a window is pending: window_data stays stable, ready_in stays 0, and no pixel is lost; the full sequence still matches REQ-031.
REQ-033 Accept pixel 23 (row 2, col 7), then pixel 24 (row 3, col 0): no window is emitted for pixel 24, and the next window after the row wrap is {8,9,10,16,17,18,24,25,26}.
REQ-034 Send two back-to-back frames with continuous valid and ready: 72 windows in total, and the first window of frame 2 equals frame 1's first window.
REQ-035 Assert rst after pixel 30, then restart the frame from 0: valid_out drops immediately, and the output matches REQ-031 exactly.
REQ-036 With CONV2D_WINGEN_FRAME_FLAGS_EN defined: win_first is high only with window {0..18} and win_last only with the window ending at 63.
